// File: rtl/ham_enc_pipe.sv
// ham_enc_pipe: two-stage Hamming(12,8) encoder with a valid/ready handshake.
// Stage 1 registers the payload byte and the error-injection request.
// Stage 2 registers the encoded codeword, with any requested bit flips applied,
// and the overall parity of that word.
// Both stages advance independently. A bubble in stage 2 therefore lets stage 1
// keep accepting data while the output is stalled.
module ham_enc_pipe #(
  parameter int CNT_W      = 16,
  parameter bit INJ_ENABLE = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [7:0]       i_data,
  input  logic             i_inj_en,
  input  logic             i_inj_double,
  input  logic [3:0]       i_inj_pos,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [11:0]      o_codeword,
  output logic             o_parity,
  output logic [CNT_W-1:0] o_word_cnt,
  input  logic             i_cnt_clr
);

  // Codeword layout shared with the decoder's syndrome logic.
  // Data occupies indices 2, 4-6 and 8-11.
  // Parity occupies indices 0, 1, 3 and 7.
  function automatic logic [11:0] encodeByte(input logic [7:0] d);
    logic [11:0] cw;
    cw       = '0;
    cw[2]    = d[0];
    cw[6:4]  = d[3:1];
    cw[11:8] = d[7:4];
    cw[0]    = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10];
    cw[1]    = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10];
    cw[3]    = cw[4] ^ cw[5] ^ cw[6] ^ cw[11];
    cw[7]    = cw[8] ^ cw[9] ^ cw[10] ^ cw[11];
    return cw;
  endfunction

  // Stage 1 state.
  logic        r_s1Valid;
  logic [7:0]  r_s1Data;
  logic        r_s1InjEn;
  logic        r_s1InjDouble;
  logic [3:0]  r_s1InjPos;

  // Stage 2 state. This state drives the outputs directly.
  logic        r_s2Valid;
  logic [11:0] r_s2Codeword;
  logic        r_s2Parity;

  logic [CNT_W-1:0] r_wordCnt;

  // Flow-control and datapath wires.
  logic        w_adv1;
  logic        w_adv2;
  logic        w_inHs;
  logic        w_outHs;
  logic [11:0] w_cwRaw;
  logic [11:0] w_injMask;
  logic [11:0] w_cwOut;
  logic        w_parOut;
  logic [3:0]  w_pos2;

  // Each stage may load when it is empty or when its contents are leaving.
  // The stall decision ripples backward within a single cycle.
  always_comb begin
    w_adv2  = ~r_s2Valid | i_ready;
    w_adv1  = ~r_s1Valid | w_adv2;
    w_inHs  = i_valid & w_adv1;
    w_outHs = r_s2Valid & i_ready;
  end

  // Stage 1 captures the payload and the injection request on an input handshake.
  // The valid flag clears when the stage advances with nothing new arriving.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1Valid     <= 1'b0;
      r_s1Data      <= '0;
      r_s1InjEn     <= 1'b0;
      r_s1InjDouble <= 1'b0;
      r_s1InjPos    <= '0;
    end else if (w_adv1) begin
      r_s1Valid <= i_valid;
      if (i_valid) begin
        r_s1Data      <= i_data;
        r_s1InjEn     <= i_inj_en;
        r_s1InjDouble <= i_inj_double;
        r_s1InjPos    <= i_inj_pos;
      end
    end
  end

  // The second flipped bit wraps from index 11 back to index 0.
  always_comb begin
    w_pos2 = (r_s1InjPos == 4'd11) ? 4'd0 : (r_s1InjPos + 4'd1);
  end

  // Build the flip mask.
  // Positions 12-15 match no codeword index, so they produce an empty mask.
  // When injection is compiled out, the mask is held at zero.
  always_comb begin
    w_injMask = '0;
    if (INJ_ENABLE && r_s1InjEn) begin
      for (int i = 0; i < 12; i++) begin
        if (r_s1InjPos == i[3:0]) begin
          w_injMask[i] = 1'b1;
        end
        if (r_s1InjDouble && (r_s1InjPos < 4'd12) && (w_pos2 == i[3:0])) begin
          w_injMask[i] = 1'b1;
        end
      end
    end
  end

  // Encode, apply the flips, then take parity over the final word.
  // The parity therefore reflects what actually leaves the block.
  always_comb begin
    w_cwRaw  = encodeByte(r_s1Data);
    w_cwOut  = w_cwRaw ^ w_injMask;
    w_parOut = ^w_cwOut;
  end

  // Stage 2 holds its word while the output is stalled.
  // It loads whatever stage 1 offers when it is allowed to advance.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s2Valid    <= 1'b0;
      r_s2Codeword <= '0;
      r_s2Parity   <= 1'b0;
    end else if (w_adv2) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Codeword <= w_cwOut;
        r_s2Parity   <= w_parOut;
      end
    end
  end

  // Output-beat counter.
  // A clear wins over a coincident handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wordCnt <= '0;
    end else if (i_cnt_clr) begin
      r_wordCnt <= '0;
    end else if (w_outHs) begin
      r_wordCnt <= r_wordCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Drive the outputs from the stage-2 state and the flow-control wires.
  always_comb begin
    o_ready    = w_adv1;
    o_valid    = r_s2Valid;
    o_codeword = r_s2Codeword;
    o_parity   = r_s2Parity;
    o_word_cnt = r_wordCnt;
  end

endmodule

// File: tb/tb_ham_enc_pipe.sv
// tb_ham_enc_pipe: scoreboard bench for ham_enc_pipe.
// Accepted beats are modelled at the input and queued.
// The output monitor pops and compares each emitted codeword.
// A second instance with a 4-bit counter and injection compiled out shares the same inputs.
module tb_ham_enc_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_inj_en = 1'b0;
  logic        i_inj_double = 1'b0;
  logic [3:0]  i_inj_pos = '0;
  logic        i_ready = 1'b0;
  logic        i_cnt_clr = 1'b0;

  logic        o_ready, o_valid, o_parity;
  logic [11:0] o_codeword;
  logic [15:0] o_word_cnt;

  logic        o_ready4, o_valid4, o_parity4;
  logic [11:0] o_codeword4;
  logic [3:0]  o_word_cnt4;

  typedef struct {
    logic [11:0] cw;
    logic        par;
    logic [11:0] cwClean;
  } exp_t;

  exp_t        sbQ[$];
  int          totalChecks = 0;
  int          badChecks = 0;
  bit          armed = 1'b0;
  bit          prevStall = 1'b0;
  logic [11:0] prevCw = '0;
  logic        prevPar = 1'b0;
  logic [15:0] cntModel = '0;
  logic [3:0]  cnt4Model = '0;

  always #5 i_clk = ~i_clk;

  ham_enc_pipe u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_inj_en(i_inj_en), .i_inj_double(i_inj_double),
    .i_inj_pos(i_inj_pos), .o_valid(o_valid), .i_ready(i_ready),
    .o_codeword(o_codeword), .o_parity(o_parity), .o_word_cnt(o_word_cnt),
    .i_cnt_clr(i_cnt_clr)
  );

  ham_enc_pipe #(.CNT_W(4), .INJ_ENABLE(1'b0)) u_dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready4),
    .i_data(i_data), .i_inj_en(i_inj_en), .i_inj_double(i_inj_double),
    .i_inj_pos(i_inj_pos), .o_valid(o_valid4), .i_ready(i_ready),
    .o_codeword(o_codeword4), .o_parity(o_parity4), .o_word_cnt(o_word_cnt4),
    .i_cnt_clr(i_cnt_clr)
  );

  // Reference encoder using positional Hamming rules.
  // Positions are 1-based; powers of two hold parity and the rest hold data in ascending order.
  // The parity bit at position p covers every position whose number has bit p set.
  function automatic logic [11:0] refEncode(input logic [7:0] d);
    logic [11:0] cw;
    int          k;
    logic        acc;
    cw = '0;
    k  = 0;
    for (int i = 0; i < 12; i++) begin
      if (((i + 1) & i) != 0) begin
        cw[i] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      acc = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if ((((i + 1) >> b) & 1) == 1 && (i + 1) != (1 << b)) acc = acc ^ cw[i];
      end
      cw[(1 << b) - 1] = acc;
    end
    return cw;
  endfunction

  function automatic logic [11:0] refMask(input logic en, input logic dbl, input logic [3:0] pos);
    logic [11:0] m;
    int          p;
    m = '0;
    p = int'(pos);
    if (en && p < 12) begin
      m[p] = 1'b1;
      if (dbl) m[(p + 1) % 12] = 1'b1;
    end
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one beat and wait, with a bound, until the DUT will accept it on the next edge.
  task automatic applyStimulus(input logic [7:0] d, input logic en, input logic dbl, input logic [3:0] pos);
    int tries;
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_data = d; i_inj_en = en; i_inj_double = dbl; i_inj_pos = pos;
    tries = 0;
    @(negedge i_clk);
    while (!o_ready && tries < 100) begin
      @(negedge i_clk);
      tries++;
    end
    if (!o_ready) checkOutput("accept_timeout", 32'(o_ready), 32'd1);
  endtask

  task automatic idle();
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_inj_en = 1'b0;
  endtask

  // Monitor and scoreboard.
  // At each falling edge, decide what the next rising edge will do, check against the models, then advance the models.
  always @(negedge i_clk) begin
    exp_t e;
    logic [11:0] m;
    logic [11:0] clean;
    if (armed) begin
      checkOutput("word_cnt", 32'(o_word_cnt), 32'(cntModel));
      checkOutput("word_cnt4", 32'(o_word_cnt4), 32'(cnt4Model));
      if (prevStall) begin
        checkOutput("stall_valid", 32'(o_valid), 32'd1);
        checkOutput("stall_cw", 32'(o_codeword), 32'(prevCw));
        checkOutput("stall_par", 32'(o_parity), 32'(prevPar));
      end
      if (i_rst_n && o_valid && i_ready) begin
        if (sbQ.size() == 0) begin
          totalChecks++;
          badChecks++;
          $display("[TB] FAIL unexpected_beat: got cw 0x%0h expected no output", o_codeword);
        end else begin
          e = sbQ.pop_front();
          checkOutput("codeword", 32'(o_codeword), 32'(e.cw));
          checkOutput("parity", 32'(o_parity), 32'(e.par));
          checkOutput("valid4", 32'(o_valid4), 32'd1);
          checkOutput("codeword4", 32'(o_codeword4), 32'(e.cwClean));
          checkOutput("parity4", 32'(o_parity4), 32'($countones(e.cwClean) % 2));
        end
      end
      if (i_rst_n && i_valid && o_ready) begin
        clean     = refEncode(i_data);
        m         = refMask(i_inj_en, i_inj_double, i_inj_pos);
        e.cwClean = clean;
        e.cw      = clean ^ m;
        e.par     = 1'($countones(clean ^ m) % 2);
        sbQ.push_back(e);
        checkOutput("ready4", 32'(o_ready4), 32'd1);
      end
    end
    prevStall = armed && i_rst_n && o_valid && !i_ready;
    prevCw    = o_codeword;
    prevPar   = o_parity;
    if (!i_rst_n) begin
      sbQ.delete();
      cntModel  = '0;
      cnt4Model = '0;
    end else if (i_cnt_clr) begin
      cntModel  = '0;
      cnt4Model = '0;
    end else if (o_valid && i_ready) begin
      cntModel  = cntModel + 16'd1;
      cnt4Model = cnt4Model + 4'd1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waits;
    // Reset and check the idle state.
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1; i_ready = 1'b1; armed = 1'b1;
    @(negedge i_clk);
    checkOutput("rst_valid", 32'(o_valid), 32'd0);
    checkOutput("rst_ready", 32'(o_ready), 32'd1);
    checkOutput("rst_cw", 32'(o_codeword), 32'd0);
    checkOutput("rst_par", 32'(o_parity), 32'd0);

    // A single 0xAA beat appears two edges after its handshake.
    applyStimulus(8'hAA, 1'b0, 1'b0, 4'd0);
    idle();
    @(negedge i_clk);
    checkOutput("lat_early_valid", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    checkOutput("aa_valid", 32'(o_valid), 32'd1);
    checkOutput("aa_cw", 32'(o_codeword), 32'hA58);
    checkOutput("aa_par", 32'(o_parity), 32'd1);
    @(negedge i_clk);
    checkOutput("aa_cnt", 32'(o_word_cnt), 32'd1);

    // Back-to-back beats, then injection cases.
    applyStimulus(8'h00, 1'b0, 1'b0, 4'd0);
    applyStimulus(8'hFF, 1'b0, 1'b0, 4'd0);
    applyStimulus(8'hAA, 1'b0, 1'b0, 4'd0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 4'd5);
    applyStimulus(8'hFF, 1'b1, 1'b1, 4'd5);
    applyStimulus(8'hFF, 1'b1, 1'b1, 4'd11);
    idle();
    repeat (4) @(negedge i_clk);

    // Backpressure: two beats fill the pipe, and then the input stalls.
    @(posedge i_clk); #1 i_ready = 1'b0;
    applyStimulus(8'h31, 1'b0, 1'b0, 4'd0);
    applyStimulus(8'h32, 1'b0, 1'b0, 4'd0);
    @(posedge i_clk); #1;
    i_data = 8'h33;
    repeat (5) begin
      @(negedge i_clk);
      checkOutput("bp_ready_low", 32'(o_ready), 32'd0);
    end
    @(posedge i_clk); #1 i_ready = 1'b1;
    waits = 0;
    @(negedge i_clk);
    while (!o_ready && waits < 20) begin @(negedge i_clk); waits++; end
    checkOutput("bp_resume_ready", 32'(o_ready), 32'd1);
    applyStimulus(8'h34, 1'b0, 1'b0, 4'd0);
    idle();
    repeat (4) @(negedge i_clk);

    // Reset with both stages full discards the in-flight beats.
    @(posedge i_clk); #1 i_ready = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b0, 4'd0);
    applyStimulus(8'h22, 1'b0, 1'b0, 4'd0);
    @(posedge i_clk); #1 i_valid = 1'b0; i_rst_n = 1'b0;
    @(posedge i_clk); #1 i_rst_n = 1'b1;
    @(negedge i_clk);
    checkOutput("mrst_valid", 32'(o_valid), 32'd0);
    checkOutput("mrst_ready", 32'(o_ready), 32'd1);
    checkOutput("mrst_cnt", 32'(o_word_cnt), 32'd0);
    @(posedge i_clk); #1 i_ready = 1'b1;

    // An out-of-range injection position leaves the word unchanged.
    applyStimulus(8'hAA, 1'b1, 1'b0, 4'd13);
    idle();
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("pos13_cw", 32'(o_codeword), 32'hA58);

    // A counter clear coincident with an output handshake wins.
    applyStimulus(8'h5A, 1'b0, 1'b0, 4'd0);
    idle();
    @(posedge i_clk); #1 i_cnt_clr = 1'b1;
    @(posedge i_clk); #1 i_cnt_clr = 1'b0;
    @(negedge i_clk);
    checkOutput("clr_cnt", 32'(o_word_cnt), 32'd0);

    // Randomised traffic, backpressure and clears.
    // The 4-bit counter instance wraps many times during this phase.
    for (int n = 0; n < 600; n++) begin
      @(posedge i_clk); #1;
      i_valid      = ($urandom_range(0, 3) != 0);
      i_data       = 8'($urandom);
      i_inj_en     = ($urandom_range(0, 2) == 0);
      i_inj_double = 1'($urandom_range(0, 1));
      i_inj_pos    = 4'($urandom_range(0, 15));
      i_ready      = ($urandom_range(0, 3) != 0);
      i_cnt_clr    = ($urandom_range(0, 79) == 0);
    end

    // Drain everything still in flight.
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
    waits = 0;
    while (sbQ.size() != 0 && waits < 20) begin @(negedge i_clk); waits++; end
    @(negedge i_clk);
    checkOutput("drain_left", 32'(sbQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/ham_enc_pipe.md
Name: ham_enc_pipe

Overview:
- Hamming(12,8) encoder with valid/ready handshake; the transmit-side counterpart of the team's Hamming decoder.
- Produces codewords in exactly the bit layout the decoder's syndrome logic expects, plus an overall-parity bit for SEC-DED extension.
- Includes a built-in error-injection path (single/double bit flip) so decoder error-detection paths can be exercised end to end.
- Sits between the RAM write-data source and the protected storage/link.

Parameters:
- CNT_W, 16, width of the output-beat counter o_word_cnt.
- INJ_ENABLE, 1, when 0 the injection logic is removed and inj inputs are ignored (codeword never flipped).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  upstream data valid.
- o_ready  output  1  encoder can accept a beat this cycle.
- i_data  input  8  payload byte.
- i_inj_en  input  1  corrupt this beat (sampled with i_data on handshake).
- i_inj_double  input  1  when i_inj_en=1, flip two bits instead of one.
- i_inj_pos  input  4  codeword index of the first flipped bit (0..11).
- o_valid  output  1  codeword valid.
- i_ready  input  1  downstream accepts codeword.
- o_codeword  output  12  encoded word.
- o_parity  output  1  XOR of all 12 bits of o_codeword as driven, including any injected flips.
- o_word_cnt  output  CNT_W  count of output handshakes.
- i_cnt_clr  input  1  synchronous clear of o_word_cnt.

Behaviour:
- Codeword layout (index 0 = LSB):
  - Data bits: cw[2]=d[0], cw[6:4]=d[3:1], cw[11:8]=d[7:4].
  - Parity bits:
    - cw[0] = cw2^cw4^cw6^cw8^cw10.
    - cw[1] = cw2^cw5^cw6^cw9^cw10.
    - cw[3] = cw4^cw5^cw6^cw11.
    - cw[7] = cw8^cw9^cw10^cw11.
  - An uncorrupted codeword yields all-zero decoder syndrome.
- Pipeline:
  - Two register stages. S1 captures i_data and the inj fields on input handshake (i_valid & o_ready).
  - S2 captures the encoded, injected codeword and its parity.
  - Latency is 2 cycles from input handshake to o_valid when unstalled. Throughput is 1 beat/cycle.
- Flow control:
  - adv2 = ~s2_valid | i_ready.
  - adv1 = ~s1_valid | adv2.
  - o_ready = adv1, purely combinational from state and i_ready.
  - While o_valid=1 and i_ready=0, o_codeword/o_parity/o_valid hold stable.
  - No beat is dropped or duplicated.
- Injection:
  - Mask m = one-hot(i_inj_pos). If i_inj_double, m also sets bit (i_inj_pos+1) mod 12, so pos 11 pairs with bit 0.
  - i_inj_pos 12..15 gives m=0 (no flip).
  - o_codeword = cw ^ m. o_parity computed after the flip.
- Counter:
  - o_word_cnt increments on each output handshake (o_valid & i_ready) and wraps modulo 2^CNT_W.
  - i_cnt_clr has priority: a simultaneous handshake is not counted (result 0).
- Reset (i_rst_n=0 at a clock edge):
  - s1_valid, s2_valid, o_valid = 0; o_codeword = 0; o_parity = 0; o_word_cnt = 0.
  - o_ready = 1 on the first cycle after reset.
  - Reset mid-stream discards in-flight beats without emitting them.
- Empty pipeline with i_ready=0: o_ready remains 1 until both stages are full.

Test Plan:
- Data 0xAA, no inject, i_ready=1 → o_valid 2 cycles later; o_codeword=0xA58, o_parity=1; o_word_cnt=1.
- Back-to-back 0x00, 0xFF, 0xAA with i_ready=1 → codewords 0x000/0, 0xF77/0, 0xA58/1 on consecutive cycles; count=3.
- 0xFF with i_inj_en=1, pos=5, double=0 → 0xF57, parity 1. The same with double=1 → 0xF17, parity 0. Pos=11, double=1 → 0x776.
- Backpressure: 4 beats in, i_ready=0 for 5 cycles → o_ready drops after 2 accepted; outputs stable; release → remaining beats emitted in order with no loss.
- Reset asserted with both stages full → next cycle o_valid=0, o_ready=1, count=0. Pos=13 inject on 0xAA → 0xA58 unchanged.
- o_word_cnt at 0xFFFF plus one handshake → 0x0000. i_cnt_clr coincident with a handshake → 0.
